// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS datapath: step states, ALU op codes
// and the sel_* multiplexer codes driven by the external decoder.
package mips_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;

  localparam logic [1:0] PC_NONE = 2'b00;
  localparam logic [1:0] PC_BRZ  = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_REG  = 2'b11;

  localparam logic [1:0] RES_MDR  = 2'b00;
  localparam logic [1:0] RES_ALU  = 2'b01;
  localparam logic [1:0] RES_LINK = 2'b10;
  localparam logic [1:0] RES_ZERO = 2'b11;

  localparam logic [1:0] WA_RT   = 2'b00;
  localparam logic [1:0] WA_RD   = 2'b01;
  localparam logic [1:0] WA_RA   = 2'b10;
  localparam logic [1:0] WA_ZERO = 2'b11;

endpackage

// File: rtl/mc_step_fsm.sv
// Step sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ack waits and a
// registered one-cycle retire pulse in the cycle after the final step.
module mc_step_fsm (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       mem_ack_i,
  input  logic       mem_rd_i,
  input  logic       mem_wr_i,
  input  logic       rf_we_i,
  output logic [2:0] state_o,
  output logic       instr_done_o
);
  import mips_pkg::*;

  logic [2:0] state_q, state_d;
  logic       done_q, done_d;

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_FETCH:  if (mem_ack_i) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (mem_rd_i || mem_wr_i) begin
          state_d = ST_MEM;
        end else if (rf_we_i) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
          done_d  = 1'b1;
        end
      end
      ST_MEM: begin
        // A store wins when both strobes are raised.
        if (mem_ack_i) begin
          if (mem_wr_i) begin
            state_d = ST_FETCH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        done_d  = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_FETCH;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign state_o      = state_q;
  assign instr_done_o = done_q;

endmodule

// File: rtl/regfile.sv
// 32-entry register file, two asynchronous read ports and one synchronous write
// port; register 0 ignores writes and always reads as zero.
module regfile #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock_i,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        raddr_a_i,
  input  logic [4:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [32];

  // NOTE: the array is deliberately not reset so it maps onto plain RAM/flops
  // without a reset tree; software writes a register before reading it.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock_i) begin
    if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath driven by an external decoder through sel_* inputs.
// Define MC_DATAPATH_PERF_EN to add the cycle_count/instr_count outputs.
module mc_datapath #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        sel_pc,
  input  logic [1:0]        sel_result,
  input  logic [1:0]        sel_wa,
  input  logic              sel_alu_b,
  input  logic              rf_we,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [3:0]        alu_ctrl,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] pc,
  output logic [31:0]       ir,
  output logic [2:0]        state,
  output logic              zero,
  output logic              instr_done
`ifdef MC_DATAPATH_PERF_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instr_count
`endif
);
  import mips_pkg::*;

  logic [DATA_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d, link_q, link_d;
  logic [31:0]       ir_q, ir_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] imm_sext, br_off, alu_b, alu_y;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, wb_data;
  logic [4:0]        wa;

  mc_step_fsm u_fsm (
    .clock_i      (clock),
    .reset_i      (reset),
    .mem_ack_i    (mem_ack),
    .mem_rd_i     (mem_rd),
    .mem_wr_i     (mem_wr),
    .rf_we_i      (rf_we),
    .state_o      (state),
    .instr_done_o (instr_done)
  );

  always_comb begin
    case (sel_wa)
      WA_RT:   wa = ir_q[20:16];
      WA_RD:   wa = ir_q[15:11];
      WA_RA:   wa = 5'd31;
      default: wa = 5'd0;
    endcase
    case (sel_result)
      RES_MDR:  wb_data = mdr_q;
      RES_ALU:  wb_data = alu_out_q;
      RES_LINK: wb_data = link_q;
      default:  wb_data = '0;
    endcase
  end

  regfile #(.DATA_W(DATA_W)) u_rf (
    .clock_i   (clock),
    .we_i      ((state == ST_WB) && !reset),
    .waddr_i   (wa),
    .wdata_i   (wb_data),
    .raddr_a_i (ir_q[25:21]),
    .raddr_b_i (ir_q[20:16]),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b)
  );

  assign imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
  assign br_off   = {{(DATA_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};
  assign alu_b    = sel_alu_b ? imm_sext : b_q;

  always_comb begin
    case (alu_ctrl)
      ALU_ADD:  alu_y = a_q + alu_b;
      ALU_SUB:  alu_y = a_q - alu_b;
      ALU_AND:  alu_y = a_q & alu_b;
      ALU_OR:   alu_y = a_q | alu_b;
      ALU_XOR:  alu_y = a_q ^ alu_b;
      ALU_NOR:  alu_y = ~(a_q | alu_b);
      ALU_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
      ALU_SLTU: alu_y = {{(DATA_W-1){1'b0}}, (a_q < alu_b)};
      ALU_SLL:  alu_y = a_q << alu_b[4:0];
      ALU_SRL:  alu_y = a_q >> alu_b[4:0];
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    link_d    = link_q;
    zero_d    = zero_q;
    case (state)
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d = mem_rdata[31:0];
          pc_d = pc_q + DATA_W'(4);
        end
      end
      ST_DECODE: begin
        a_d = rf_rdata_a;
        b_d = rf_rdata_b;
      end
      ST_EXEC: begin
        alu_out_d = alu_y;
        zero_d    = (alu_y == '0);
        link_d    = pc_q;
        // The branch tests this cycle's ALU result, not the registered flag.
        case (sel_pc)
          PC_BRZ:  if (alu_y == '0) pc_d = pc_q + br_off;
          PC_JUMP: pc_d = {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};
          PC_REG:  pc_d = a_q;
          default: ;
        endcase
      end
      ST_MEM: if (mem_ack && !mem_wr) mdr_d = mem_rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      link_q    <= '0;
      zero_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      link_q    <= link_d;
      zero_q    <= zero_d;
    end
  end

  // Address/strobe come only from registers held across wait cycles.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    if (state == ST_FETCH) begin
      mem_req = 1'b1;
    end else if (state == ST_MEM) begin
      mem_req  = 1'b1;
      mem_we   = mem_wr;
      mem_addr = alu_out_q;
    end
  end

  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign zero      = zero_q;

`ifdef MC_DATAPATH_PERF_EN
  logic [31:0] cycle_q, instr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (instr_done) instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`endif

endmodule
